// File: rtl/apb_gpio_edge_irq.sv
// APB GPIO edge-detect / interrupt stage: sync, optional debounce, rise/fall
// detection into a W1C pending register, masked level IRQ. Debounce via GPIO_IRQ_DEBOUNCE_EN.
module apb_gpio_edge_irq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic [31:0]      PADDR,
  input  logic             PWRITE,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  input  logic [WIDTH-1:0] GPIO_DI,
  input  logic [WIDTH-1:0] GPIO_INEN,
  output logic             IRQ
);

  typedef enum logic [2:0] {
    REG_IN    = 3'd0,
    REG_RISE  = 3'd1,
    REG_FALL  = 3'd2,
    REG_PEND  = 3'd3,
    REG_IE    = 3'd4,
    REG_DBDIV = 3'd5
  } reg_sel_e;

  logic [2:0]       reg_sel;
  logic             wr_en;
  logic [WIDTH-1:0] wdat;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] ie;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] pend_set;
  logic [WIDTH-1:0] pend_clr;
  logic [WIDTH-1:0] rd_pins;
  logic [31:0]      rd_word;
  logic             unused_bits;

  assign reg_sel     = PADDR[4:2];
  assign wr_en       = PSEL & PENABLE & PWRITE;
  assign wdat        = PWDATA[WIDTH-1:0];
  assign PREADY      = 1'b1;
  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= GPIO_DI;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic [15:0]      dbdiv;
  logic [15:0]      presc;
  logic             tick;
  logic [WIDTH-1:0] samp [3];
  logic [WIDTH-1:0] all_hi;
  logic [WIDTH-1:0] all_lo;

  assign tick   = (presc == dbdiv);
  assign all_hi = samp[0] & samp[1] & samp[2];
  assign all_lo = ~(samp[0] | samp[1] | samp[2]);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dbdiv <= '0;
      presc <= '0;
      filt  <= '0;
      for (int unsigned k = 0; k < 3; k++) samp[k] <= '0;
    end else begin
      if (wr_en && reg_sel == REG_DBDIV) begin
        dbdiv <= PWDATA[15:0];
        presc <= '0;
      end else if (tick) begin
        presc <= '0;
      end else begin
        presc <= presc + 16'd1;
      end
      if (tick) begin
        samp[0] <= sync_q[SYNC_STAGES-1];
        samp[1] <= samp[0];
        samp[2] <= samp[1];
      end
      // filt only moves once three consecutive tick samples agree
      filt <= (filt | all_hi) & ~all_lo;
    end
  end
`else
  assign filt = sync_q[SYNC_STAGES-1];
`endif

  // prev always follows filt, so a masked pin carries no stale history
  assign rise     = filt & ~prev & GPIO_INEN;
  assign fall     = ~filt & prev & GPIO_INEN;
  assign pend_set = (rise & rise_en) | (fall & fall_en);
  assign pend_clr = (wr_en && reg_sel == REG_PEND) ? wdat : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      prev    <= '0;
      rise_en <= '0;
      fall_en <= '0;
      pend    <= '0;
      ie      <= '0;
      IRQ     <= 1'b0;
    end else begin
      prev <= filt;
      pend <= (pend & ~pend_clr) | pend_set;
      IRQ  <= |(pend & ie);
      if (wr_en) begin
        case (reg_sel)
          REG_RISE: rise_en <= wdat;
          REG_FALL: fall_en <= wdat;
          REG_IE:   ie      <= wdat;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    rd_pins = '0;
    rd_word = '0;
    if (PSEL) begin
      case (reg_sel)
        REG_IN:   rd_pins = filt & GPIO_INEN;
        REG_RISE: rd_pins = rise_en;
        REG_FALL: rd_pins = fall_en;
        REG_PEND: rd_pins = pend;
        REG_IE:   rd_pins = ie;
        default:  rd_pins = '0;
      endcase
    end
    rd_word[WIDTH-1:0] = rd_pins;
`ifdef GPIO_IRQ_DEBOUNCE_EN
    if (PSEL && reg_sel == REG_DBDIV) rd_word[15:0] = dbdiv;
`endif
    PRDATA = rd_word;
  end

endmodule
